// File: rtl/xo_input_pkg.sv
// Shared definitions for the XO board input path: cell count, index width and
// the move-arbiter state encoding (also used by the game FSM and display driver).
package xo_input_pkg;

   localparam int N_CELLS    = 9;
   localparam int CELL_IDX_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OFFER   = 2'd1,
      LOCKOUT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/move_request_arbiter_rr_picker.sv
// Round-robin picker: lowest requesting index strictly above `last`, wrapping.
// Rotates the request vector so last+1 sits at bit 0, priority-encodes, rotates back.
module rr_picker #(
   parameter int N_BTN = 9,
   parameter int IDX_W = 4
) (
   input  logic [N_BTN-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N_BTN);

   logic [IDX_W-1:0]   w_start;
   logic [2*N_BTN-1:0] w_dbl;
   logic [N_BTN-1:0]   w_rot;
   logic [IDX_W-1:0]   w_pos;
   logic               w_found;
   logic [IDX_W:0]     w_sum;

   assign w_start = (last >= IDX_W'(N_BTN-1)) ? '0 : last + IDX_W'(1);
   assign w_dbl   = {req, req};
   assign w_rot   = N_BTN'(w_dbl >> w_start);

   always_comb begin
      w_pos   = '0;
      w_found = 1'b0;
      for (int i = N_BTN-1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_pos   = IDX_W'(i);
            w_found = 1'b1;
         end
      end
   end

   assign w_sum = {1'b0, w_start} + {1'b0, w_pos};
   assign any   = |req;

   always_comb begin
      idx = '0;
      if (w_found) begin
         if (w_sum >= N_EXT) idx = IDX_W'(w_sum - N_EXT);
         else                idx = w_sum[IDX_W-1:0];
      end
   end

endmodule

// File: rtl/move_request_arbiter.sv
// Collects button press pulses into sticky pending bits and offers one cell at a
// time to the game FSM over valid/ready, with a lockout window after each move.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | nothing offered; pick a pending cell when enabled
//   OFFER   | move_valid high, move_idx frozen until move_ready
//   LOCKOUT | counting down LOCKOUT_CYCLES after an accepted move
module move_request_arbiter
   import xo_input_pkg::*;
#(
   parameter int N_BTN          = N_CELLS,
   parameter int IDX_W          = CELL_IDX_W,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int LOCK_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] press,
   input  logic             enable,
   output logic             move_valid,
   output logic [IDX_W-1:0] move_idx,
   input  logic             move_ready,
   output logic [N_BTN-1:0] pending,
   output logic             busy
);

   arb_state_t       r_state;
   logic [N_BTN-1:0] r_pending;
   logic             r_move_valid;
   logic [IDX_W-1:0] r_move_idx;
   logic             r_busy;
   logic [LOCK_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_last;

   logic             w_hs;
   logic [N_BTN-1:0] w_clr;
   logic [N_BTN-1:0] w_pending_nxt;
   logic             w_pick_any;
   logic [IDX_W-1:0] w_pick_idx;

   rr_picker #(
      .N_BTN (N_BTN),
      .IDX_W (IDX_W)
   ) u_rr_picker (
      .req  (r_pending),
      .last (r_last),
      .any  (w_pick_any),
      .idx  (w_pick_idx)
   );

   // enable low blocks the handshake even if move_ready is high
   assign w_hs  = (r_state == OFFER) && r_move_valid && move_ready && enable;
   assign w_clr = w_hs ? ({{(N_BTN-1){1'b0}}, 1'b1} << r_move_idx) : '0;

   // a press landing on the clearing cycle keeps its bit set
   assign w_pending_nxt = enable ? ((r_pending & ~w_clr) | press) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pending <= '0;
      else     r_pending <= w_pending_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_move_valid <= 1'b0;
         r_move_idx   <= '0;
         r_busy       <= 1'b0;
         r_cnt        <= '0;
         r_last       <= IDX_W'(N_BTN-1);
      end else begin
         case (r_state)
            IDLE: begin
               if (enable && w_pick_any) begin
                  r_move_idx   <= w_pick_idx;
                  r_move_valid <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= OFFER;
               end
            end
            OFFER: begin
               if (!enable) begin
                  r_move_valid <= 1'b0;
                  r_busy       <= 1'b0;
                  r_state      <= IDLE;
               end else if (w_hs) begin
                  r_move_valid <= 1'b0;
                  r_last       <= r_move_idx;
                  r_cnt        <= LOCK_W'(LOCKOUT_CYCLES-1);
                  r_state      <= LOCKOUT;
               end
            end
            LOCKOUT: begin
               if (r_cnt == '0) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - LOCK_W'(1);
               end
            end
            default: begin
               r_move_valid <= 1'b0;
               r_busy       <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

   assign move_valid = r_move_valid;
   assign move_idx   = r_move_idx;
   assign pending    = r_pending;
   assign busy       = r_busy;

endmodule

// File: tb/tb_move_request_arbiter.sv
// Scoreboard bench for move_request_arbiter with LOCKOUT_CYCLES = 4.
module tb_move_request_arbiter;

   localparam int N   = 9;
   localparam int IW  = 4;
   localparam int LOC = 4;

   logic          clk;
   logic          rst;
   logic [N-1:0]  press;
   logic          enable;
   logic          move_valid;
   logic [IW-1:0] move_idx;
   logic          move_ready;
   logic [N-1:0]  pending;
   logic          busy;

   int n_checks;
   int n_errors;
   int cyc;
   int exp_q[$];
   int hs_log[$];

   move_request_arbiter #(
      .N_BTN          (N),
      .IDX_W          (IW),
      .LOCKOUT_CYCLES (LOC),
      .LOCK_W         (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .press      (press),
      .enable     (enable),
      .move_valid (move_valid),
      .move_idx   (move_idx),
      .move_ready (move_ready),
      .pending    (pending),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // handshake monitor: each accepted move must match the scoreboard head
   always @(negedge clk) begin
      int e;
      if (!rst && enable && move_valid && move_ready) begin
         hs_log.push_back(cyc);
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL hs_unexpected: got idx %0d, required no move", move_idx);
         end else begin
            e = exp_q.pop_front();
            if (int'(move_idx) !== e) begin
               n_errors++;
               $display("FAIL hs_idx: got %0d, required %0d", move_idx, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((busy || move_valid || exp_q.size() != 0) && n < 200) begin
         step();
         n++;
      end
      n_checks++;
      if (n >= 200) begin
         n_errors++;
         $display("FAIL %s_timeout: busy=%0b valid=%0b queued=%0d, required idle and drained",
                  name, busy, move_valid, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; press = '0; enable = 1'b0; move_ready = 1'b0;
      step();
      step();
      n_checks++;
      if ({move_valid, move_idx, pending, busy} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got valid=%0b idx=%0d pending=%h busy=%0b, required all 0",
                  move_valid, move_idx, pending, busy);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      int n_busy;
      int n;
      enable = 1'b1; move_ready = 1'b1;
      press = 9'h010; exp_q.push_back(4);
      step();
      press = '0;
      n_checks++;
      if (pending !== 9'h010 || move_valid !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL single_latch: got pending=%h valid=%0b busy=%0b, required 010/0/0",
                  pending, move_valid, busy);
      end
      step();
      n_checks++;
      if (move_valid !== 1'b1 || move_idx !== 4'd4 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL single_offer: got valid=%0b idx=%0d busy=%0b, required 1/4/1",
                  move_valid, move_idx, busy);
      end
      step();
      n_checks++;
      if (move_valid !== 1'b0 || pending !== '0) begin
         n_errors++;
         $display("FAIL single_clear: got valid=%0b pending=%h, required 0/000", move_valid, pending);
      end
      n_busy = 1 + int'(busy);
      n = 0;
      while (busy && n < 50) begin
         step();
         n++;
         if (busy) n_busy++;
      end
      n_checks++;
      if (n_busy != 1 + LOC) begin
         n_errors++;
         $display("FAIL single_busy_len: got %0d cycles, required %0d", n_busy, 1 + LOC);
      end
      wait_done("single");
   endtask

   task automatic test_round_robin();
      hs_log.delete();
      move_ready = 1'b1;
      press = 9'h005; exp_q.push_back(0); exp_q.push_back(2);
      step();
      press = '0;
      wait_done("rr_a");
      n_checks++;
      if (hs_log.size() != 2) begin
         n_errors++;
         $display("FAIL rr_count: got %0d handshakes, required 2", hs_log.size());
      end else if (hs_log[1] - hs_log[0] != LOC + 2) begin
         n_errors++;
         $display("FAIL rr_spacing: got %0d cycles, required %0d", hs_log[1] - hs_log[0], LOC + 2);
      end
      // last = 2, so the search wraps and cell 0 precedes cell 1
      press = 9'h003; exp_q.push_back(0); exp_q.push_back(1);
      step();
      press = '0;
      wait_done("rr_b");
   endtask

   task automatic test_back_to_back_pressure();
      bit stable;
      hs_log.delete();
      move_ready = 1'b0;
      press = 9'h100; exp_q.push_back(8);
      step();
      press = '0;
      step();
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (move_valid !== 1'b1 || move_idx !== 4'd8) stable = 1'b0;
         step();
      end
      n_checks++;
      if (!stable || move_valid !== 1'b1 || move_idx !== 4'd8) begin
         n_errors++;
         $display("FAIL bp_stable: got valid=%0b idx=%0d, required held 1/8", move_valid, move_idx);
      end
      move_ready = 1'b1;
      step();
      n_checks++;
      if (move_valid !== 1'b0 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_lockout_start: got valid=%0b busy=%0b, required 0/1", move_valid, busy);
      end
      wait_done("bp");
      n_checks++;
      if (hs_log.size() != 1) begin
         n_errors++;
         $display("FAIL bp_single_hs: got %0d handshakes, required 1", hs_log.size());
      end
   endtask

   task automatic test_lockout_latch();
      move_ready = 1'b1;
      press = 9'h002; exp_q.push_back(1);
      step();
      press = '0;
      step();
      step();
      press = 9'h080; exp_q.push_back(7);
      step();
      press = '0;
      n_checks++;
      if (pending !== 9'h080 || move_valid !== 1'b0 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL latch_pending: got pending=%h valid=%0b busy=%0b, required 080/0/1",
                  pending, move_valid, busy);
      end
      step();
      step();
      step();
      n_checks++;
      if (move_valid !== 1'b0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL latch_exit: got valid=%0b busy=%0b, required 0/0", move_valid, busy);
      end
      step();
      n_checks++;
      if (move_valid !== 1'b1 || move_idx !== 4'd7) begin
         n_errors++;
         $display("FAIL latch_offer: got valid=%0b idx=%0d, required 1/7", move_valid, move_idx);
      end
      wait_done("latch");
   endtask

   task automatic test_flush();
      move_ready = 1'b0;
      press = 9'h028;
      step();
      press = '0;
      step();
      n_checks++;
      if (move_valid !== 1'b1 || move_idx !== 4'd3) begin
         n_errors++;
         $display("FAIL flush_offer: got valid=%0b idx=%0d, required 1/3", move_valid, move_idx);
      end
      enable = 1'b0; move_ready = 1'b1;
      step();
      n_checks++;
      if (move_valid !== 1'b0 || pending !== '0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_drop: got valid=%0b pending=%h busy=%0b, required 0/000/0",
                  move_valid, pending, busy);
      end
      press = 9'h004;
      step();
      press = '0;
      step();
      n_checks++;
      if (pending !== '0 || move_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_discard: got pending=%h valid=%0b, required 000/0", pending, move_valid);
      end
      enable = 1'b1;
      wait_done("flush");
   endtask

   task automatic test_async_reset();
      move_ready = 1'b0;
      press = 9'h040;
      step();
      press = '0;
      step();
      n_checks++;
      if (move_valid !== 1'b1 || move_idx !== 4'd6) begin
         n_errors++;
         $display("FAIL arst_offer: got valid=%0b idx=%0d, required 1/6", move_valid, move_idx);
      end
      #3 rst = 1'b1;
      #1;
      n_checks++;
      if (move_valid !== 1'b0 || pending !== '0 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL arst_async: got valid=%0b pending=%h busy=%0b, required 0/000/0",
                  move_valid, pending, busy);
      end
      step();
      rst = 1'b0;
      move_ready = 1'b1;
      press = 9'h003; exp_q.push_back(0); exp_q.push_back(1);
      step();
      press = '0;
      wait_done("arst");
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_back_to_back_pressure();
      test_lockout_latch();
      test_flush();
      test_async_reset();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL sb_drained: got %0d moves outstanding, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
